// File: rtl/threshold_binarizer_pkg.sv
// Shared definitions for the threshold binarizer: default widths, reset
// threshold and the frame state enumeration.
package threshold_binarizer_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_COORD_W     = 16;
    localparam int DEF_COUNT_W     = 20;
    localparam int DEF_THRESH_INIT = 128;

    // SYNC waits for a frame gap after reset, IDLE waits for frame start,
    // ACTIVE binarizes and accumulates, REPORT publishes frame statistics.
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/threshold_binarizer_if.sv
// Pixel event stream: a start-of-frame marker, a qualified pixel with a
// one-bit flag and its coordinates. The master produces events, the slave
// consumes them.
interface threshold_binarizer_if
    import threshold_binarizer_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
);
    logic               sof;
    logic               valid;
    logic               flag;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;

    modport master (output sof, output valid, output flag, output x, output y);
    modport slave  (input  sof, input  valid, input  flag, input  x, input  y);
endinterface

// File: rtl/frame_bbox_accum.sv
// Per-frame foreground accumulators: saturating pixel count and an unsigned
// bounding box. A start-of-frame event re-initialises everything and folds
// in the pixel presented on that same cycle.
module frame_bbox_accum
    import threshold_binarizer_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_srst,
    threshold_binarizer_if.slave s_ev,
    output logic [COUNT_W-1:0]   o_count,
    output logic [COORD_W-1:0]   o_min_x,
    output logic [COORD_W-1:0]   o_max_x,
    output logic [COORD_W-1:0]   o_min_y,
    output logic [COORD_W-1:0]   o_max_y,
    output logic                 o_any_fg
);

    localparam logic [COORD_W-1:0] COORD_ONES = '1;

    logic [COUNT_W-1:0] r_count;
    logic               r_any_fg;
    logic [COORD_W-1:0] r_min [2];
    logic [COORD_W-1:0] r_max [2];
    logic [COORD_W-1:0] w_coord [2];
    logic               w_hit;

    assign w_hit      = s_ev.valid & s_ev.flag;
    assign w_coord[0] = s_ev.x;
    assign w_coord[1] = s_ev.y;

    // Foreground counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_count  <= '0;
            r_any_fg <= 1'b0;
        end else if (s_ev.sof) begin
            r_count  <= w_hit ? COUNT_W'(1) : '0;
            r_any_fg <= w_hit;
        end else if (w_hit) begin
            if (!(&r_count)) begin
                r_count <= r_count + COUNT_W'(1);
            end
            r_any_fg <= 1'b1;
        end
    end

    // One min/max tracker per axis (0 = x, 1 = y).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            // Min starts at all-ones and max at zero so the first hit sets both.
            always_ff @(posedge i_clk) begin
                if (i_srst) begin
                    r_min[gi] <= COORD_ONES;
                    r_max[gi] <= '0;
                end else if (s_ev.sof) begin
                    r_min[gi] <= w_hit ? w_coord[gi] : COORD_ONES;
                    r_max[gi] <= w_hit ? w_coord[gi] : '0;
                end else if (w_hit) begin
                    if (w_coord[gi] < r_min[gi]) begin
                        r_min[gi] <= w_coord[gi];
                    end
                    if (w_coord[gi] > r_max[gi]) begin
                        r_max[gi] <= w_coord[gi];
                    end
                end
            end
        end
    endgenerate

    assign o_count  = r_count;
    assign o_any_fg = r_any_fg;
    assign o_min_x  = r_min[0];
    assign o_max_x  = r_max[0];
    assign o_min_y  = r_min[1];
    assign o_max_y  = r_max[1];

endmodule

// File: rtl/threshold_binarizer.sv
// Streaming gray-to-binary thresholder with per-frame foreground statistics.
// The threshold is frozen at frame start; updates arriving mid-frame wait in
// a pending register until the next frame.
module threshold_binarizer
    import threshold_binarizer_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                COORD_W     = DEF_COORD_W,
    parameter int                COUNT_W     = DEF_COUNT_W,
    parameter logic [DATA_W-1:0] THRESH_INIT = DATA_W'(DEF_THRESH_INIT)
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [DATA_W-1:0]  iGray,
    input  logic               iGrayValid,
    input  logic               iFvalid,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    input  logic [DATA_W-1:0]  iThresh,
    input  logic               iThreshValid,
    output logic               oBin,
    output logic               oBinValid,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic [COUNT_W-1:0] oFgCount,
    output logic [COORD_W-1:0] oMinX,
    output logic [COORD_W-1:0] oMaxX,
    output logic [COORD_W-1:0] oMinY,
    output logic [COORD_W-1:0] oMaxY,
    output logic               oBoxValid,
    output logic [DATA_W-1:0]  oFrameThresh,
    output logic               oStatsValid
);

    state_t             r_state;
    logic [DATA_W-1:0]  r_pend_thresh;
    logic [DATA_W-1:0]  r_frame_thresh;

    logic               r_bin;
    logic               r_bin_valid;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    logic [COUNT_W-1:0] r_fg_count;
    logic [COORD_W-1:0] r_min_x;
    logic [COORD_W-1:0] r_max_x;
    logic [COORD_W-1:0] r_min_y;
    logic [COORD_W-1:0] r_max_y;
    logic               r_box_valid;
    logic [DATA_W-1:0]  r_out_thresh;
    logic               r_stats_valid;

    logic               w_accept;
    logic               w_start;
    logic [DATA_W-1:0]  w_start_thresh;
    logic [DATA_W-1:0]  w_eff_thresh;
    logic               w_fg;

    logic [COUNT_W-1:0] w_acc_count;
    logic [COORD_W-1:0] w_acc_min_x;
    logic [COORD_W-1:0] w_acc_max_x;
    logic [COORD_W-1:0] w_acc_min_y;
    logic [COORD_W-1:0] w_acc_max_y;
    logic               w_acc_any;

    // Pixels only count inside a frame that began after synchronisation.
    assign w_accept = iGrayValid & iFvalid &
                      ((r_state == ST_IDLE) | (r_state == ST_ACTIVE));
    assign w_start  = (r_state == ST_IDLE) & iFvalid;

    // A strobe coinciding with frame start is used directly for that frame.
    assign w_start_thresh = iThreshValid ? iThresh : r_pend_thresh;
    assign w_eff_thresh   = w_start ? w_start_thresh : r_frame_thresh;
    assign w_fg           = iGray > w_eff_thresh;

    threshold_binarizer_if #(.COORD_W(COORD_W)) w_ev_if ();

    assign w_ev_if.sof   = w_start;
    assign w_ev_if.valid = w_accept;
    assign w_ev_if.flag  = w_fg;
    assign w_ev_if.x     = iX_Cont;
    assign w_ev_if.y     = iY_Cont;

    frame_bbox_accum #(
        .COORD_W (COORD_W),
        .COUNT_W (COUNT_W)
    ) u_accum (
        .i_clk    (iClk),
        .i_srst   (iRst),
        .s_ev     (w_ev_if),
        .o_count  (w_acc_count),
        .o_min_x  (w_acc_min_x),
        .o_max_x  (w_acc_max_x),
        .o_min_y  (w_acc_min_y),
        .o_max_y  (w_acc_max_y),
        .o_any_fg (w_acc_any)
    );

    // Binarized pixel path: one register stage after acceptance.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_bin_valid <= 1'b0;
            r_bin       <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            r_bin_valid <= w_accept;
            r_bin       <= w_accept & w_fg;
            r_x         <= w_accept ? iX_Cont : '0;
            r_y         <= w_accept ? iY_Cont : '0;
        end
    end

    // Frame state machine, threshold registers and registered statistics.
    // Statistics load on the ACTIVE->REPORT edge so they are visible while
    // the machine sits in REPORT; the accumulators are already final then
    // because no pixel is accepted once iFvalid is low.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state        <= ST_SYNC;
            r_pend_thresh  <= THRESH_INIT;
            r_frame_thresh <= THRESH_INIT;
            r_fg_count     <= '0;
            r_min_x        <= '0;
            r_max_x        <= '0;
            r_min_y        <= '0;
            r_max_y        <= '0;
            r_box_valid    <= 1'b0;
            r_out_thresh   <= THRESH_INIT;
            r_stats_valid  <= 1'b0;
        end else begin
            r_stats_valid <= 1'b0;
            if (iThreshValid) begin
                r_pend_thresh <= iThresh;
            end
            case (r_state)
                ST_SYNC: begin
                    if (!iFvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (iFvalid) begin
                        r_state        <= ST_ACTIVE;
                        r_frame_thresh <= w_start_thresh;
                    end
                end
                ST_ACTIVE: begin
                    if (!iFvalid) begin
                        r_state       <= ST_REPORT;
                        r_stats_valid <= 1'b1;
                        r_fg_count    <= w_acc_count;
                        r_box_valid   <= w_acc_any;
                        r_min_x       <= w_acc_any ? w_acc_min_x : '0;
                        r_max_x       <= w_acc_any ? w_acc_max_x : '0;
                        r_min_y       <= w_acc_any ? w_acc_min_y : '0;
                        r_max_y       <= w_acc_any ? w_acc_max_y : '0;
                        r_out_thresh  <= r_frame_thresh;
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

    assign oBin         = r_bin;
    assign oBinValid    = r_bin_valid;
    assign oX           = r_x;
    assign oY           = r_y;
    assign oFgCount     = r_fg_count;
    assign oMinX        = r_min_x;
    assign oMaxX        = r_max_x;
    assign oMinY        = r_min_y;
    assign oMaxY        = r_max_y;
    assign oBoxValid    = r_box_valid;
    assign oFrameThresh = r_out_thresh;
    assign oStatsValid  = r_stats_valid;

endmodule
